// File: rtl/instr_mem_loader_pkg.sv
// rtl/instr_mem_loader_pkg.sv - shared widths, NOP encoding and state type for the instruction-memory loader
package instr_mem_loader_pkg;
   localparam int ADDR_W_DEF  = 8;
   localparam int INSTR_W_DEF = 16;
   localparam int NOP         = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } state_t;
endpackage

// File: rtl/instr_mem_loader_if.sv
// rtl/instr_mem_loader_if.sv - host/PC/decoder signal bundle of the instruction-memory loader
interface instr_mem_loader_if #(
   parameter int ADDR_W  = instr_mem_loader_pkg::ADDR_W_DEF,
   parameter int INSTR_W = instr_mem_loader_pkg::INSTR_W_DEF
);
   logic               load_start;
   logic               run_start;
   logic [ADDR_W:0]    prog_len;
   logic [7:0]         rx_data;
   logic               rx_valid;
   logic [ADDR_W-1:0]  addr_in;
   logic [INSTR_W-1:0] instr_out;
   logic               cpu_rst;
   logic               load_busy;
   logic               load_done;

   modport master (
      output load_start, run_start, prog_len, rx_data, rx_valid, addr_in,
      input  instr_out, cpu_rst, load_busy, load_done
   );

   modport slave (
      input  load_start, run_start, prog_len, rx_data, rx_valid, addr_in,
      output instr_out, cpu_rst, load_busy, load_done
   );
endinterface

// File: rtl/instr_mem_loader_instr_ram.sv
// rtl/instr_mem_loader_instr_ram.sv - simple dual-port instruction RAM, registered read that outputs NOP when disabled
module instr_ram #(
   parameter int ADDR_W  = instr_mem_loader_pkg::ADDR_W_DEF,
   parameter int INSTR_W = instr_mem_loader_pkg::INSTR_W_DEF
) (
   input  logic               clk,
   input  logic               we,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [INSTR_W-1:0] wr_data,
   input  logic               rd_en,
   input  logic [ADDR_W-1:0]  rd_addr,
   output logic [INSTR_W-1:0] rd_data
);
   import instr_mem_loader_pkg::*;

   logic [INSTR_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Nonblocking read gives old data on a same-address write in the same cycle.
   always_ff @(posedge clk) begin
      rd_data <= rd_en ? mem[rd_addr] : INSTR_W'(NOP);
   end
endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - loads a byte stream into instruction RAM, then serves PC-addressed instructions
module instr_mem_loader #(
   parameter int ADDR_W  = instr_mem_loader_pkg::ADDR_W_DEF,
   parameter int INSTR_W = instr_mem_loader_pkg::INSTR_W_DEF
) (
   input logic              clk,
   input logic              RST,
   instr_mem_loader_if.slave bus
);
   import instr_mem_loader_pkg::*;

   localparam int BPI   = INSTR_W / 8;
   localparam int CNT_W = $clog2(BPI + 1);

   state_t             state;
   logic [ADDR_W:0]    len_q;
   logic [ADDR_W-1:0]  wr_addr;
   logic [CNT_W-1:0]   byte_cnt;
   logic [INSTR_W-1:0] asm_q;
   logic [INSTR_W+7:0] shifted;
   logic               start_load;
   logic               last_byte;
   logic               ram_we;
   logic               ram_rd_en;

   assign start_load = bus.load_start && (bus.prog_len != '0);
   assign last_byte  = bus.rx_valid && (byte_cnt == CNT_W'(BPI - 1));
   // Low INSTR_W bits of {assembly, byte} are the completed word, also the next assembly value.
   assign shifted    = {asm_q, bus.rx_data};
   assign ram_we     = (state == ST_LOAD) && last_byte;
   assign ram_rd_en  = (state == ST_RUN) && !RST && !start_load;

   always_ff @(posedge clk) begin
      if (RST) begin
         state         <= ST_IDLE;
         bus.cpu_rst   <= 1'b1;
         bus.load_busy <= 1'b0;
         bus.load_done <= 1'b0;
         byte_cnt      <= '0;
         wr_addr       <= '0;
         len_q         <= '0;
         asm_q         <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               bus.cpu_rst <= 1'b1;
               if (start_load) begin
                  state         <= ST_LOAD;
                  len_q         <= bus.prog_len;
                  wr_addr       <= '0;
                  byte_cnt      <= '0;
                  bus.load_done <= 1'b0;
                  bus.load_busy <= 1'b1;
               end else if (bus.run_start) begin
                  state <= ST_RUN;
               end
            end
            ST_LOAD: begin
               bus.cpu_rst <= 1'b1;
               if (bus.rx_valid) begin
                  asm_q <= shifted[INSTR_W-1:0];
                  if (last_byte) begin
                     byte_cnt <= '0;
                     wr_addr  <= wr_addr + 1'b1;
                     if ({1'b0, wr_addr} == len_q - 1'b1) begin
                        state         <= ST_RUN;
                        bus.load_done <= 1'b1;
                        bus.load_busy <= 1'b0;
                     end
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (start_load) begin
                  state         <= ST_LOAD;
                  len_q         <= bus.prog_len;
                  wr_addr       <= '0;
                  byte_cnt      <= '0;
                  bus.load_done <= 1'b0;
                  bus.load_busy <= 1'b1;
                  bus.cpu_rst   <= 1'b1;
               end else begin
                  bus.cpu_rst <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   instr_ram #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W)
   ) u_ram (
      .clk     (clk),
      .we      (ram_we),
      .wr_addr (wr_addr),
      .wr_data (shifted[INSTR_W-1:0]),
      .rd_en   (ram_rd_en),
      .rd_addr (bus.addr_in),
      .rd_data (bus.instr_out)
   );
endmodule
